serial_subtractor: RTL

//  Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_sub_cell.sv | 19 +
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e : FSM state encoding (idle = 0, run = 1, done = 2).
// Build option: define SERIAL_SUB_ADD_MODE_EN to add the 'op' add/subtract select port.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_cell.sv
// Gate-level one-bit full adder used as the serial arithmetic cell.
//   a, b, carryin : addend bits and incoming carry
//   sum, carryout : sum bit and outgoing carry
// Any inversion of b for subtraction is done by the instantiating module.
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  logic a_x_b;

  assign a_x_b    = a ^ b;
  assign sum      = a_x_b ^ carryin;
  assign carryout = (a & b) | (carryin & a_x_b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-adder cell computes a + ~b + 1 with a carry register between bits.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : load a/b and begin (honoured in idle or done only)
//   a, b                : operands, sampled on the accepting edge
//   op                  : (SERIAL_SUB_ADD_MODE_EN only) 1 = subtract, 0 = add
//   busy                : high while bits are processed (WIDTH cycles)
//   done                : one-cycle pulse, results valid from this cycle
//   diff                : result modulo 2^WIDTH
//   borrowout           : subtract: unsigned a < b; add: final carry out
//   overflow            : signed overflow (carry into MSB ^ carry out of MSB)
// Build option: SERIAL_SUB_ADD_MODE_EN adds the 'op' port and add mode.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             overflow
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] diff_q;
  logic             carry_q;
  logic             borrow_q;
  logic             overflow_q;
  logic             accept;
  logic             last_bit;
  logic             sub_mode;
  logic             sub_mode_in;
  logic             cell_sum;
  logic             cell_carry;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic op_q;

  assign sub_mode    = op_q;
  assign sub_mode_in = op;
`else
  assign sub_mode    = 1'b1;
  assign sub_mode_in = 1'b1;
`endif

  assign last_bit = (count_q == WIDTH'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and accept decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (last_bit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // b is inverted only when subtracting.
  serial_sub_cell u_cell (
    .a        (a_q[0]),
    .b        (b_q[0] ^ sub_mode),
    .carryin  (carry_q),
    .sum      (cell_sum),
    .carryout (cell_carry)
  );

  // Datapath: operand shifters, carry, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_q       <= 1'b1;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      count_q <= '0;
      // The +1 of two's-complement negation enters as the initial carry.
      carry_q <= sub_mode_in;
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_q    <= op;
`endif
    end else if (state_q == StRun) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= cell_carry;
      count_q <= count_q + 1'b1;
      // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      diff_q  <= {cell_sum, diff_q[WIDTH-1:1]};
      if (last_bit) begin
        overflow_q <= carry_q ^ cell_carry;
        borrow_q   <= sub_mode ? ~cell_carry : cell_carry;
      end
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign diff      = diff_q;
  assign borrowout = borrow_q;
  assign overflow  = overflow_q;

endmodule
